// File: rtl/scrambler_pkg.sv
// scrambler_pkg: definitions shared by the 802.11 x^7+x^4+1 scrambler and descrambler.
package scrambler_pkg;

  localparam int LFSR_W           = 7;
  localparam int TAP_HI           = 6;
  localparam int TAP_LO           = 3;
  localparam int SYNC_BITS_DEF    = 7;
  localparam int SERVICE_BITS_DEF = 16;
  localparam int CNT_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SERVICE,
    ST_RUN
  } desc_state_e;

  // Returns {next_state, fb}; the feedback bit is shifted in at s[0].
  function automatic logic [LFSR_W:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_HI] ^ s[TAP_LO];
    return {s[LFSR_W-2:0], fb, fb};
  endfunction

endpackage

// File: rtl/descrambler_80211.sv
// descrambler_80211: 802.11 receive descrambler, recovers the seed from the zero SYNC bits of SERVICE.
// Define SERVICE_CHECK_EN to flag nonzero reserved SERVICE bits and an all-zero recovered seed.
module descrambler_80211
  import scrambler_pkg::*;
#(
  parameter int SYNC_BITS    = SYNC_BITS_DEF,
  parameter int SERVICE_BITS = SERVICE_BITS_DEF,
  parameter bit DROP_SERVICE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              bit_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [LFSR_W-1:0] state_out,
  output logic              locked,
  output logic              service_err
);

  localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] SERVICE_LAST = CNT_W'(SERVICE_BITS - 1);
  localparam logic [CNT_W-1:0] SERVICE_END  = CNT_W'(SERVICE_BITS);

  desc_state_e       fsm_q, fsm_d;
  logic [LFSR_W-1:0] s_q, s_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              locked_q, locked_d;
  logic [LFSR_W:0]   step;
  logic              desc_bit;
`ifdef SERVICE_CHECK_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    step        = lfsr_step(s_q);
    desc_bit    = bit_in ^ step[0];
    count_inc   = (count_q == SERVICE_END) ? count_q : count_q + 1'b1;
    fsm_d       = fsm_q;
    s_d         = s_q;
    count_d     = count_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    locked_d    = locked_q;
`ifdef SERVICE_CHECK_EN
    err_d       = err_q;
`endif

    // A frame start aborts whatever is in progress and takes the bit as SYNC bit 0.
    if (start) begin
      fsm_d    = ST_SYNC;
      locked_d = 1'b0;
      count_d  = '0;
`ifdef SERVICE_CHECK_EN
      err_d    = 1'b0;
`endif
      if (enable) begin
        s_d     = {s_q[LFSR_W-2:0], bit_in};
        count_d = CNT_W'(1);
      end
    end else if (enable) begin
      unique case (fsm_q)
        ST_IDLE: begin
        end
        ST_SYNC: begin
          s_d     = {s_q[LFSR_W-2:0], bit_in};
          count_d = count_inc;
          if (count_q == SYNC_LAST) begin
            fsm_d    = ST_SERVICE;
            locked_d = 1'b1;
`ifdef SERVICE_CHECK_EN
            if (s_d == '0) err_d = 1'b1;
`endif
          end
        end
        ST_SERVICE: begin
          bit_out_d   = desc_bit;
          bit_valid_d = !DROP_SERVICE;
          s_d         = step[LFSR_W:1];
          count_d     = count_inc;
          if (count_q == SERVICE_LAST) fsm_d = ST_RUN;
`ifdef SERVICE_CHECK_EN
          if (desc_bit) err_d = 1'b1;
`endif
        end
        ST_RUN: begin
          bit_out_d   = desc_bit;
          bit_valid_d = 1'b1;
          s_d         = step[LFSR_W:1];
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      s_q         <= '0;
      count_q     <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      locked_q    <= 1'b0;
`ifdef SERVICE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      s_q         <= s_d;
      count_q     <= count_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      locked_q    <= locked_d;
`ifdef SERVICE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign state_out = s_q;
  assign locked    = locked_q;
`ifdef SERVICE_CHECK_EN
  assign service_err = err_q;
`else
  assign service_err = 1'b0;
`endif

endmodule

// File: tb/tb_descrambler_80211.sv
// tb_descrambler_80211: directed checks of the descrambler against hand-scrambled 802.11 streams.
// Two instances share the stimulus: SERVICE bits dropped (default) and SERVICE bits emitted.
module tb_descrambler_80211;

  // Bit i of each constant is stream bit i (sent first = bit 0).
  // Seed 7'h5D, 16 zero SERVICE bits, payload 8'hA5 LSB-first.
  localparam logic [23:0] STREAM_5D   = 24'h309836;
  // Seed 7'h7F, 16 zero SERVICE bits, payload 8'hA5 LSB-first.
  localparam logic [23:0] STREAM_7F   = 24'h364F70;
  // Seed 7'h00: no scrambling, payload 8'h3C passes through.
  localparam logic [23:0] STREAM_ZERO = 24'h3C0000;
  // STREAM_5D with SERVICE bit 10 inverted.
  localparam logic [23:0] STREAM_FLIP = 24'h309C36;
`ifdef SERVICE_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        enable;
  logic        start;
  logic        bit_in;
  logic        bit_out, bit_valid, locked, service_err;
  logic [6:0]  state_out;
  logic        bit_out_ns, bit_valid_ns, locked_ns, service_err_ns;
  logic [6:0]  state_out_ns;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] out_vec, out_vec_ns;
  int          out_cnt, out_cnt_ns;

  descrambler_80211 dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .bit_in      (bit_in),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .state_out   (state_out),
    .locked      (locked),
    .service_err (service_err)
  );

  descrambler_80211 #(.DROP_SERVICE(1'b0)) dut_ns (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .bit_in      (bit_in),
    .bit_out     (bit_out_ns),
    .bit_valid   (bit_valid_ns),
    .state_out   (state_out_ns),
    .locked      (locked_ns),
    .service_err (service_err_ns)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and records every valid output bit, oldest first.
  task automatic applyStimulus(input logic en, input logic st, input logic b);
    @(negedge clock);
    enable = en;
    start  = st;
    bit_in = b;
    @(posedge clock);
    #1;
    if (bit_valid === 1'b1 && out_cnt < 64) begin
      out_vec[out_cnt] = bit_out;
      out_cnt++;
    end
    if (bit_valid_ns === 1'b1 && out_cnt_ns < 64) begin
      out_vec_ns[out_cnt_ns] = bit_out_ns;
      out_cnt_ns++;
    end
  endtask

  task automatic clearCapture();
    out_vec    = '0;
    out_vec_ns = '0;
    out_cnt    = 0;
    out_cnt_ns = 0;
  endtask

  // Sends stream bits first..last (start rides on bit 0); optional idle cycle after each bit.
  task automatic sendBits(input logic [23:0] s, input int first, input int last, input logic gaps,
                          input logic [6:0] lock_state, input string tag);
    for (int i = first; i <= last; i++) begin
      applyStimulus(1'b1, i == 0, s[i]);
      if (i == 0) checkOutput({tag, "_locked_b0"}, {31'd0, locked}, 32'd0);
      if (i == 5) checkOutput({tag, "_locked_b5"}, {31'd0, locked}, 32'd0);
      if (i == 6) begin
        checkOutput({tag, "_locked_b6"}, {31'd0, locked}, 32'd1);
        checkOutput({tag, "_lock_state"}, {25'd0, state_out}, {25'd0, lock_state});
        checkOutput({tag, "_ns_locked_b6"}, {31'd0, locked_ns}, 32'd1);
        checkOutput({tag, "_ns_lock_state"}, {25'd0, state_out_ns}, {25'd0, lock_state});
      end
      if (gaps) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_gap_valid"}, {31'd0, bit_valid}, 32'd0);
        checkOutput({tag, "_gap_valid_ns"}, {31'd0, bit_valid_ns}, 32'd0);
        if (i == 6) checkOutput({tag, "_gap_state_held"}, {25'd0, state_out}, {25'd0, lock_state});
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    start  = 1'b0;
    bit_in = 1'b0;
    clearCapture();
    #12;
    $display("[TB] reset values");
    checkOutput("rst_bit_out", {31'd0, bit_out}, 32'd0);
    checkOutput("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    checkOutput("rst_state", {25'd0, state_out}, 32'd0);
    checkOutput("rst_locked", {31'd0, locked}, 32'd0);
    checkOutput("rst_service_err", {31'd0, service_err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_state", {25'd0, state_out}, 32'd0);

    $display("[TB] loopback seed 5D");
    clearCapture();
    sendBits(STREAM_5D, 0, 23, 1'b0, 7'h36, "loop");
    checkOutput("loop_pulses", out_cnt, 32'd8);
    checkOutput("loop_payload", {24'd0, out_vec[7:0]}, 32'hA5);
    checkOutput("loop_ns_pulses", out_cnt_ns, 32'd17);
    checkOutput("loop_ns_service", {23'd0, out_vec_ns[8:0]}, 32'd0);
    checkOutput("loop_ns_payload", {24'd0, out_vec_ns[16:9]}, 32'hA5);
    checkOutput("loop_service_err", {31'd0, service_err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("loop_idle_valid", {31'd0, bit_valid}, 32'd0);

    $display("[TB] enable gaps");
    clearCapture();
    sendBits(STREAM_5D, 0, 23, 1'b1, 7'h36, "gaps");
    checkOutput("gaps_pulses", out_cnt, 32'd8);
    checkOutput("gaps_payload", {24'd0, out_vec[7:0]}, 32'hA5);
    checkOutput("gaps_ns_pulses", out_cnt_ns, 32'd17);
    checkOutput("gaps_ns_payload", {24'd0, out_vec_ns[16:9]}, 32'hA5);

    $display("[TB] start mid-run");
    sendBits(STREAM_5D, 0, 18, 1'b0, 7'h36, "abort");
    checkOutput("abort_locked_run", {31'd0, locked}, 32'd1);
    clearCapture();
    sendBits(STREAM_7F, 0, 23, 1'b0, 7'h07, "restart");
    checkOutput("restart_pulses", out_cnt, 32'd8);
    checkOutput("restart_payload", {24'd0, out_vec[7:0]}, 32'hA5);
    checkOutput("restart_ns_pulses", out_cnt_ns, 32'd17);
    checkOutput("restart_ns_payload", {24'd0, out_vec_ns[16:9]}, 32'hA5);

    $display("[TB] async reset mid-sync");
    sendBits(STREAM_5D, 0, 4, 1'b0, 7'h36, "rsync");
    checkOutput("rsync_bit_out_before", {31'd0, bit_out}, 32'd1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rsync_bit_out", {31'd0, bit_out}, 32'd0);
    checkOutput("rsync_state", {25'd0, state_out}, 32'd0);
    checkOutput("rsync_locked", {31'd0, locked}, 32'd0);
    checkOutput("rsync_valid", {31'd0, bit_valid}, 32'd0);
    checkOutput("rsync_ns_state", {25'd0, state_out_ns}, 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    clearCapture();
    sendBits(STREAM_5D, 0, 23, 1'b0, 7'h36, "relock");
    checkOutput("relock_payload", {24'd0, out_vec[7:0]}, 32'hA5);
    checkOutput("relock_pulses", out_cnt, 32'd8);

    $display("[TB] all-zero recovered state");
    clearCapture();
    sendBits(STREAM_ZERO, 0, 23, 1'b0, 7'h00, "zero");
    checkOutput("zero_state_run", {25'd0, state_out}, 32'd0);
    checkOutput("zero_payload", {24'd0, out_vec[7:0]}, 32'h3C);
    checkOutput("zero_service_err", {31'd0, service_err}, {31'd0, CHECK_EN});

    $display("[TB] corrupted SERVICE bit 10");
    clearCapture();
    sendBits(STREAM_FLIP, 0, 9, 1'b0, 7'h36, "flip");
    checkOutput("flip_err_b9", {31'd0, service_err}, 32'd0);
    sendBits(STREAM_FLIP, 10, 10, 1'b0, 7'h36, "flip");
    checkOutput("flip_err_b10", {31'd0, service_err}, {31'd0, CHECK_EN});
    checkOutput("flip_ns_err_b10", {31'd0, service_err_ns}, {31'd0, CHECK_EN});
    checkOutput("flip_ns_bit10", {31'd0, out_vec_ns[3]}, 32'd1);
    sendBits(STREAM_FLIP, 11, 23, 1'b0, 7'h36, "flip");
    checkOutput("flip_err_held", {31'd0, service_err}, {31'd0, CHECK_EN});
    checkOutput("flip_payload", {24'd0, out_vec[7:0]}, 32'hA5);
    checkOutput("flip_ns_payload", {24'd0, out_vec_ns[16:9]}, 32'hA5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("flip_err_cleared", {31'd0, service_err}, 32'd0);
    checkOutput("flip_locked_cleared", {31'd0, locked}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
